fft_peak_finder: RTL and testbench



---
 rtl/fft_peak_finder.sv | 134 +++++++++++++
 tb/tb_fft_peak_finder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_finder.sv
`default_nettype none
// ============================================================================
// Module      : fft_peak_finder
// Description : Scans a streamed FFT magnitude frame, tracks the strongest bin
//               inside the search window and reports the 5-bit compressed
//               peak magnitude plus its bin index once per completed frame.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_peak_finder #(
    parameter int N_BINS    = 256,  // bins per frame (2..256)
    parameter int SKIP_LOW  = 2,    // bins below this index never win
    parameter int SCAN_BINS = 128,  // bins at or above this index never win
    parameter int SHIFT     = 6     // peak magnitude right shift before saturation
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low
    input  logic        i_valid,
    input  logic        i_sop,
    input  logic [15:0] i_magn,
    output logic        o_valid,
    output logic [4:0]  o_magn,
    output logic [7:0]  o_max_id,
    output logic        o_frame_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] LAST_BIN = 8'(N_BINS - 1);
    // Window bounds held in 9 bits so SCAN_BINS = 256 is representable.
    localparam logic [8:0] WIN_LO   = 9'(SKIP_LOW);
    localparam logic [8:0] WIN_HI   = 9'(SCAN_BINS);

    logic [1:0]  state;
    logic [7:0]  bin_cnt;
    logic [15:0] best_mag;
    logic [7:0]  best_id;

    logic        start;
    logic        in_scan;
    logic        accept;
    logic        abort;
    logic        last_beat;
    logic        in_window;
    logic        take;
    logic [7:0]  eval_idx;
    logic [7:0]  base_id;
    logic [15:0] base_mag;
    logic [7:0]  next_id;
    logic [15:0] next_mag;
    logic [15:0] shifted;
    logic [4:0]  magn_sat;

    // Beat classification and peak comparison; a sop beat is always bin 0
    // evaluated against a cleared best, whichever state it arrives in.
    always_comb begin
        start     = i_valid & i_sop;
        in_scan   = (state == ST_SCAN);
        accept    = start | (in_scan & i_valid);
        abort     = in_scan & start;
        last_beat = in_scan & i_valid & ~i_sop & (bin_cnt == LAST_BIN);

        eval_idx  = start ? 8'd0  : bin_cnt;
        base_mag  = start ? 16'd0 : best_mag;
        base_id   = start ? 8'd0  : best_id;

        in_window = ({1'b0, eval_idx} >= WIN_LO) && ({1'b0, eval_idx} < WIN_HI);
        // Strict compare keeps the lowest index on ties.
        take      = in_window && (i_magn > base_mag);
        next_mag  = take ? i_magn   : base_mag;
        next_id   = take ? eval_idx : base_id;

        shifted   = next_mag >> SHIFT;
        magn_sat  = (shifted > 16'd31) ? 5'd31 : shifted[4:0];
    end

    // Frame state: any sop enters SCAN, the last bin enters DONE for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else if (start) begin
            state <= ST_SCAN;
        end else if (last_beat) begin
            state <= ST_DONE;
        end else if (!in_scan) begin
            state <= ST_IDLE;
        end
    end

    // Bin counter: points at the index of the next beat to be evaluated.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_cnt <= 8'd0;
        end else if (start) begin
            bin_cnt <= 8'd1;
        end else if (last_beat) begin
            bin_cnt <= 8'd0;
        end else if (in_scan && i_valid) begin
            bin_cnt <= bin_cnt + 8'd1;
        end
    end

    // Running best over the accepted beats of the current frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_mag <= 16'd0;
            best_id  <= 8'd0;
        end else if (accept) begin
            best_mag <= next_mag;
            best_id  <= next_id;
        end
    end

    // Result registers: loaded from the final comparison so the last bin
    // counts and o_valid coincides with the DONE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_magn      <= 5'd0;
            o_max_id    <= 8'd0;
        end else begin
            o_valid     <= last_beat;
            o_frame_err <= abort;
            if (last_beat) begin
                o_magn   <= magn_sat;
                o_max_id <= next_id;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_finder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_peak_finder
// Description : Self-checking scoreboard bench for fft_peak_finder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_peak_finder;

    localparam int SKIP_LOW  = 2;
    localparam int SCAN_BINS = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_sop = 1'b0;
    logic [15:0] i_magn = 16'd0;
    logic        o_valid;
    logic [4:0]  o_magn;
    logic [7:0]  o_max_id;
    logic        o_frame_err;

    fft_peak_finder #(
        .N_BINS(256), .SKIP_LOW(SKIP_LOW), .SCAN_BINS(SCAN_BINS), .SHIFT(6)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_sop(i_sop), .i_magn(i_magn),
        .o_valid(o_valid), .o_magn(o_magn), .o_max_id(o_max_id),
        .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] id;
        logic [4:0] mg;
        int         cyc;
    } exp_t;

    exp_t        sbq[$];
    int          errq[$];
    logic [15:0] frame [256];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          abort_pending = 0;
    logic [7:0]  last_id = 8'd0;
    logic [4:0]  last_mg = 5'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: strongest bin strictly greater, searched in rising index order.
    function automatic void model(output logic [7:0] id, output logic [4:0] mg);
        logic [15:0] best;
        logic [15:0] s;
        best = 16'd0;
        id   = 8'd0;
        for (int i = SKIP_LOW; i < SCAN_BINS; i++) begin
            if (frame[i] > best) begin
                best = frame[i];
                id   = 8'(i);
            end
        end
        s  = best >> 6;
        mg = (s > 16'd31) ? 5'd31 : s[4:0];
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < 256; i++) frame[i] = 16'd0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_sop   = 1'($urandom_range(1));
        i_magn  = 16'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) idle_cycle();
    endtask

    // Drives bins 0..nbeats-1 of frame[]; a short frame is left aborted.
    task automatic run_frame(input int nbeats, input int gap_pct);
        exp_t e;
        for (int b = 0; b < nbeats; b++) begin
            while (int'($urandom_range(99)) < gap_pct) idle_cycle();
            @(posedge clk); #1;
            i_valid = 1'b1;
            i_sop   = (b == 0);
            i_magn  = frame[b];
            if (b == 0 && abort_pending) errq.push_back(cyc + 1);
            if (b == nbeats - 1 && nbeats == 256) begin
                model(e.id, e.mg);
                e.cyc = cyc + 1;
                sbq.push_back(e);
            end
        end
        abort_pending = (nbeats < 256);
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (o_valid && o_frame_err) check("valid_and_err", 1, 0);
        if (o_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("max_id", 32'(o_max_id), 32'(e.id));
                check("magn", 32'(o_magn), 32'(e.mg));
                check("valid_cycle", cyc, e.cyc);
                last_id = e.id;
                last_mg = e.mg;
            end
        end
        if (o_frame_err) begin
            if (errq.size() == 0) begin
                check("unexpected_err", 1, 0);
            end else begin
                check("err_cycle", cyc, errq.pop_front());
                check("err_keeps_id", 32'(o_max_id), 32'(last_id));
                check("err_keeps_magn", 32'(o_magn), 32'(last_mg));
            end
        end
    end

    initial begin
        clear_frame();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_magn", 32'(o_magn), 0);
        check("rst_id", 32'(o_max_id), 0);
        check("rst_err", 32'(o_frame_err), 0);

        // Non-sop beats in IDLE are ignored.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            i_valid = 1'b1; i_sop = 1'b0; i_magn = 16'hFFFF;
        end
        idle(3);

        // Single peak at 37.
        clear_frame(); frame[37] = 16'd1000;
        run_frame(256, 0); idle(4);

        // DC and mirror bins excluded, saturation.
        clear_frame();
        frame[0] = 16'd60000; frame[1] = 16'd50000;
        frame[200] = 16'd40000; frame[90] = 16'd5000;
        run_frame(256, 0); idle(4);

        // Tie with random gaps: lowest index wins.
        clear_frame(); frame[40] = 16'd640; frame[12] = 16'd640;
        run_frame(256, 30); idle(4);

        // Window edges: bin 127 is in, bin 128 is out.
        clear_frame(); frame[127] = 16'd64; frame[128] = 16'd9000; frame[2] = 16'd63;
        run_frame(256, 0); idle(4);

        // Frame A aborted at bin 100, then a full frame B.
        clear_frame(); frame[50] = 16'd3000;
        run_frame(100, 0);
        clear_frame(); frame[70] = 16'd2000;
        run_frame(256, 0); idle(4);

        // Back-to-back frames, sop on the DONE cycle.
        clear_frame(); frame[10] = 16'd700;
        run_frame(256, 0);
        clear_frame(); frame[20] = 16'd1280;
        run_frame(256, 0);

        // Reset mid third frame.
        clear_frame(); frame[30] = 16'd4000;
        run_frame(50, 0);
        #2 rst = 1'b0;
        #1;
        check("midrst_valid", 32'(o_valid), 0);
        check("midrst_magn", 32'(o_magn), 0);
        check("midrst_id", 32'(o_max_id), 0);
        check("midrst_err", 32'(o_frame_err), 0);
        abort_pending = 0;
        last_id = 8'd0;
        last_mg = 5'd0;
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        idle(300);

        // Bounded drain, then any leftover expectation is a failure.
        for (int i = 0; i < 20 && (sbq.size() != 0 || errq.size() != 0); i++) idle_cycle();
        check("sb_drained", sbq.size(), 0);
        check("err_drained", errq.size(), 0);
        check("end_magn", 32'(o_magn), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
